rs232_avs: RTL and testbench

RS232_AVS -- requirements
Module: rs232_avs

---
 rtl/rs232_pkg.sv | 30 +++
 rtl/rs232_rx_deser.sv | 101 ++++++++++
 rtl/rs232_avs.sv | 216 +++++++++++++++++++++
 tb/tb_rs232_avs.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared register map, status bit positions and FSM state types for the rs232_avs slave.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;
  localparam int FE_BIT    = 1;
  localparam int OV_BIT    = 0;

  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_PTR_W      = $clog2(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  function automatic logic [31:0] status_word(input logic rx_ok, input logic tx_ok,
                                              input logic fe, input logic ov);
    logic [31:0] w;
    w            = '0;
    w[RX_OK_BIT] = rx_ok;
    w[TX_OK_BIT] = tx_ok;
    w[FE_BIT]    = fe;
    w[OV_BIT]    = ov;
    return w;
  endfunction

endpackage

// File: rtl/rs232_rx_deser.sv
// Serial receiver: 2-flop synchroniser plus 8N1 deserialiser with one-cycle byte-valid
// and framing-error pulses.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | counting to mid start bit, then re-checking it is still low
// RX_DATA  | sampling 8 data bits, LSB first, DIV cycles apart
// RX_STOP  | sampling stop bit; high delivers the byte, low flags a framing error
module rs232_rx_deser import rs232_pkg::*; #(
  parameter int DIV = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  // [0] metastability flop, [1] synchronised line, [2] previous synchronised value
  logic [2:0]    sync_q;
  logic          rxd_s;
  logic          fall;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q;
  logic          ferr_q;

  assign rxd_s = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], rxd_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            state_q <= RX_START;
            cnt_q   <= CNT_HALF;
          end
        end
        RX_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!rxd_s) begin
            state_q <= RX_DATA;
            cnt_q   <= CNT_FULL;
            bit_q   <= '0;
          end else begin
            state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q <= {rxd_s, shift_q[7:1]};
            cnt_q   <= CNT_FULL;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            if (rxd_s) valid_q <= 1'b1;
            else       ferr_q  <= 1'b1;
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // shift_q is stable until the next frame reaches RX_DATA, so it doubles as the byte output
  assign byte_o  = shift_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/rs232_avs.sv
// Avalon-MM UART slave with two-cycle accesses; RX buffering is a 16-deep FIFO when
// RS232_RX_FIFO_EN is defined, otherwise a single holding byte.
//
// state    | meaning
// TX_IDLE  | line high; moves the holding byte into the shifter when one is pending
// TX_START | start bit low for DIV cycles
// TX_DATA  | 8 data bits LSB first, DIV cycles each
// TX_STOP  | stop bit high for DIV cycles
module rs232_avs import rs232_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

  if (DIV < 4) begin : g_div_check
    $error("rs232_avs: CLK_HZ/BAUD must be at least 4");
  end

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;
  logic        rx_ok;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        rx_overrun;
  logic        push_ok;

  logic        phase_q;
  logic        cyc_a;
  logic        rx_rd_q;
  logic        tx_wr_q;
  logic        st_rd_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        fe_q;
  logic        ov_q;

  tx_state_e   tx_state_q;
  logic        tx_ok_q;
  logic        tx_load;
  logic [7:0]  tx_hold_q;
  logic [7:0]  tx_shift_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic        txd_q;

  logic        unused_wdata;
  assign unused_wdata = ^avm_writedata[31:8];

  rs232_rx_deser #(.DIV(DIV)) u_rx (
    .clk_i   (avm_clk),
    .rst_i   (avm_rst),
    .rxd_i   (uart_rxd),
    .byte_o  (rx_byte),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr)
  );

`ifdef RS232_RX_FIFO_EN
  logic [7:0]          fifo_mem [RX_FIFO_DEPTH];
  logic [RX_PTR_W-1:0] wr_ptr_q;
  logic [RX_PTR_W-1:0] rd_ptr_q;
  logic [RX_PTR_W:0]   count_q;

  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok    = rx_valid & ((count_q != (RX_PTR_W+1)'(RX_FIFO_DEPTH)) | rx_pop);
  assign rx_overrun = rx_valid & ~push_ok;
  assign rx_ok      = (count_q != '0);
  assign rx_data    = fifo_mem[rd_ptr_q];

  always_ff @(posedge avm_clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + RX_PTR_W'(1);
      if (rx_pop)  rd_ptr_q <= rd_ptr_q + RX_PTR_W'(1);
      count_q <= count_q + (RX_PTR_W+1)'(push_ok) - (RX_PTR_W+1)'(rx_pop);
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign push_ok    = rx_valid & (~hold_vld_q | rx_pop);
  assign rx_overrun = rx_valid & ~push_ok;
  assign rx_ok      = hold_vld_q;
  assign rx_data    = hold_q;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      if (push_ok) hold_q <= rx_byte;
      hold_vld_q <= push_ok | (hold_vld_q & ~rx_pop);
    end
  end
`endif

  assign cyc_a           = (avm_read | avm_write) & ~phase_q;
  assign avm_waitrequest = cyc_a;
  assign avm_readdata    = rdata_q;
  assign rx_pop          = rx_rd_q;
  assign tx_load         = tx_wr_q & tx_ok_q;
  assign uart_txd        = txd_q;

  always_comb begin
    rdata_d = '0;
    if (avm_read) begin
      if (avm_address == RX_BASE && rx_ok) rdata_d = {24'b0, rx_data};
      else if (avm_address == STATUS_BASE) rdata_d = status_word(rx_ok, tx_ok_q, fe_q, ov_q);
    end
  end

  // the decision to pop is taken in cycle A so an empty-read can never pop a byte
  // that arrives between the two cycles
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      phase_q <= 1'b0;
      rx_rd_q <= 1'b0;
      tx_wr_q <= 1'b0;
      st_rd_q <= 1'b0;
      rdata_q <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      phase_q <= cyc_a;
      rx_rd_q <= cyc_a & avm_read  & (avm_address == RX_BASE) & rx_ok;
      tx_wr_q <= cyc_a & avm_write & (avm_address == TX_BASE);
      st_rd_q <= cyc_a & avm_read  & (avm_address == STATUS_BASE);
      if (cyc_a) rdata_q <= rdata_d;
      fe_q <= rx_ferr    | (fe_q & ~st_rd_q);
      ov_q <= rx_overrun | (ov_q & ~st_rd_q);
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_state_q <= TX_IDLE;
      tx_ok_q    <= 1'b1;
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      if (tx_load) begin
        tx_hold_q <= avm_writedata[7:0];
        tx_ok_q   <= 1'b0;
      end
      case (tx_state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (!tx_ok_q) begin
            tx_shift_q <= tx_hold_q;
            tx_ok_q    <= 1'b1;
            txd_q      <= 1'b0;
            tx_cnt_q   <= CNT_FULL;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end else begin
            txd_q      <= tx_shift_q[0];
            tx_cnt_q   <= CNT_FULL;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end else begin
            tx_cnt_q <= CNT_FULL;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              txd_q      <= tx_shift_q[1];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - CW'(1);
          else                tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_avs.sv
// Directed bench for rs232_avs at DIV=10: register-map vector table plus RX, TX,
// overrun, framing-error and mid-frame reset sequences.
module tb_rs232_avs;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;
`ifdef RS232_RX_FIFO_EN
  localparam int RX_DEPTH = 16;
`else
  localparam int RX_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  avm_address = '0;
  logic        avm_read = 1'b0;
  logic        avm_write = 1'b0;
  logic [31:0] avm_writedata = '0;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs232_avs #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .avm_clk         (clk),
    .avm_rst         (rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .uart_rxd        (uart_rxd),
    .uart_txd        (uart_txd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one complete two-cycle access; readdata is checked for writes too (must read 0)
  task automatic bus(input logic wr, input logic [4:0] addr, input logic [7:0] wd,
                     input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    avm_address   = addr;
    avm_writedata = {24'h0, wd};
    avm_read      = ~wr;
    avm_write     = wr;
    @(negedge clk);
    check({name, " waitreq_A"}, {31'b0, avm_waitrequest}, 32'd1);
    @(posedge clk); #1;
    check({name, " waitreq_B"}, {31'b0, avm_waitrequest}, 32'd0);
    check({name, " readdata"}, avm_readdata, exp);
    @(posedge clk); #1;
    avm_read  = 1'b0;
    avm_write = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      uart_rxd = fr[i];
      repeat (DIV - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    uart_rxd = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // serial monitor: mid-bit samples of each frame on uart_txd, bit k = k-th bit in time
  logic [9:0] frames[$];
  logic       mon_prev = 1'b1;
  logic [9:0] mon_f;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_prev && !uart_txd) begin
        repeat (4) @(negedge clk);
        mon_f[0] = uart_txd;
        for (int k = 1; k < 10; k++) begin
          repeat (DIV) @(negedge clk);
          mon_f[k] = uart_txd;
        end
        frames.push_back(mon_f);
        mon_prev = 1'b1;
      end else begin
        mon_prev = uart_txd;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [7:0]  wd;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs [11];
  logic [9:0] exp_tx;

  initial begin
    vecs[0]  = '{1'b0, 5'd8,  8'h00, 32'h40};
    vecs[1]  = '{1'b0, 5'd0,  8'h00, 32'h00};
    vecs[2]  = '{1'b0, 5'd4,  8'h00, 32'h00};
    vecs[3]  = '{1'b0, 5'd12, 8'h00, 32'h00};
    vecs[4]  = '{1'b0, 5'd3,  8'h00, 32'h00};
    vecs[5]  = '{1'b1, 5'd8,  8'hFF, 32'h00};
    vecs[6]  = '{1'b1, 5'd0,  8'h55, 32'h00};
    vecs[7]  = '{1'b1, 5'd16, 8'hAA, 32'h00};
    vecs[8]  = '{1'b0, 5'd8,  8'h00, 32'h40};
    vecs[9]  = '{1'b0, 5'd0,  8'h00, 32'h00};
    vecs[10] = '{1'b0, 5'd31, 8'h00, 32'h00};

    repeat (3) @(posedge clk); #1;
    check("rst waitreq", {31'b0, avm_waitrequest}, 32'd0);
    check("rst readdata", avm_readdata, 32'h0);
    check("rst txd", {31'b0, uart_txd}, 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++)
      bus(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp, $sformatf("vec%0d", i));
    check("idle txd", {31'b0, uart_txd}, 32'd1);

    // receive one byte
    send(8'hA5, 1'b1);
    bus(1'b0, 5'd8, 8'h00, 32'hC0, "rx status_full");
    bus(1'b0, 5'd0, 8'h00, 32'hA5, "rx data");
    bus(1'b0, 5'd8, 8'h00, 32'h40, "rx status_empty");

    // transmit: first byte goes straight to the shifter, second waits, third is discarded
    frames.delete();
    bus(1'b1, 5'd4, 8'h3C, 32'h00, "tx wr1");
    bus(1'b0, 5'd8, 8'h00, 32'h40, "tx status_after_load");
    bus(1'b1, 5'd4, 8'h81, 32'h00, "tx wr2");
    bus(1'b0, 5'd8, 8'h00, 32'h00, "tx status_busy");
    bus(1'b1, 5'd4, 8'h7E, 32'h00, "tx wr3_discard");
    repeat (300) @(posedge clk);
    check("tx frame_count", frames.size(), 32'd2);
    if (frames.size() >= 1) begin
      exp_tx = 10'b1001111000;
      for (int k = 0; k < 10; k++)
        check($sformatf("tx 3C bit%0d", k), {31'b0, frames[0][k]}, {31'b0, exp_tx[k]});
    end
    if (frames.size() >= 2)
      check("tx frame2", {22'b0, frames[1]}, {22'b0, 10'b1100000010});
    bus(1'b0, 5'd8, 8'h00, 32'h40, "tx status_done");

    // overrun: one byte more than storage holds
    for (int i = 0; i <= RX_DEPTH; i++) send(8'(i * 7 + 3), 1'b1);
    bus(1'b0, 5'd8, 8'h00, 32'hC1, "ovr status");
    for (int i = 0; i < RX_DEPTH; i++)
      bus(1'b0, 5'd0, 8'h00, 32'(8'(i * 7 + 3)), $sformatf("ovr data%0d", i));
    bus(1'b0, 5'd8, 8'h00, 32'h40, "ovr status_cleared");

    // framing error
    send(8'h5A, 1'b0);
    bus(1'b0, 5'd8, 8'h00, 32'h42, "fe status");
    bus(1'b0, 5'd0, 8'h00, 32'h00, "fe no_data");
    bus(1'b0, 5'd8, 8'h00, 32'h40, "fe status_cleared");

    // reset with both directions mid-frame
    bus(1'b1, 5'd4, 8'h00, 32'h00, "rstmid tx_wr");
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    repeat (35) @(posedge clk); #1;
    check("rstmid txd_low", {31'b0, uart_txd}, 32'd0);
    rst = 1'b1;
    uart_rxd = 1'b1;
    #1;
    check("rstmid txd_abort", {31'b0, uart_txd}, 32'd1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (150) @(posedge clk);
    bus(1'b0, 5'd8, 8'h00, 32'h40, "rstmid status");
    bus(1'b0, 5'd0, 8'h00, 32'h00, "rstmid rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
